imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and drives the word-indexed, combinational-read instruction memory.
- Each cycle it fetches one instruction into a 2-entry queue and presents it to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the queue.
- Traps out-of-range and misaligned PCs into a sticky FAULT state.
- Sits between the instruction memory and the decode stage of the MIPS core.

Parameters:
DEPTH, 32, number of 32-bit words in instruction memory; legal word index is 0..DEPTH-1.
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  pulse; IDLE -> RUN.
stop  in  1  pulse; RUN -> IDLE, queue retained.
imem_addr  out  32  word index to instruction memory, equal to pc >> 2 (zero-extended).
imem_rdata  in  32  instruction word; combinational in imem_addr.
out_valid  out  1  queue head valid.
out_ready  in  1  decode accepts the head.
out_instr  out  32  head instruction.
out_pc  out  32  byte PC of the head instruction.
redir_valid  in  1  redirect request (taken beq or j).
redir_pc  in  32  redirect target byte address.
fault  out  1  sticky fault flag.
fault_pc  out  32  byte PC that faulted.

Behaviour:
- State machine: IDLE, RUN, FAULT.
- Reset state: IDLE, pc = RESET_PC, queue empty.
- Output reset values:
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - fault = 0, fault_pc = 0.
  - imem_addr = RESET_PC >> 2.
- Reset mid-operation discards all state regardless of phase.
- IDLE:
  - No fetch.
  - start -> RUN on the next edge.
  - If redir_valid is high, pc <= redir_pc. This applies alone or together with start; start + redirect enters RUN with pc = redir_pc.
- RUN fetch, each cycle in priority order:
  - (1) Redirect:
    - Flush both queue entries and set pc <= redir_pc.
    - No fetch that cycle; out_valid = 0 the following cycle.
    - A pop in the same cycle (out_valid & out_ready) counts as delivered.
  - (2) Fault:
    - Condition: pc[1:0] != 0, or (pc >> 2) >= DEPTH.
    - Action: no push, fault <= 1, fault_pc <= pc, state <= FAULT.
  - (3) Fetch: occurs if count < 2, or count == 2 with a pop this cycle.
    - Push {imem_rdata, pc}.
    - pc <= pc + 4; 32-bit arithmetic wraps modulo 2^32, but the bounds check catches overflow first.
  - (4) Otherwise stall: pc holds.
- stop in RUN:
  - Fetch still occurs this cycle, then state <= IDLE.
  - redir_valid takes priority over stop within the cycle; both are applied.
- Queue and handshake:
  - out_valid = (count != 0); head is always the oldest entry.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - out_instr and out_pc are held stable while out_valid & !out_ready.
- Latency:
  - start at edge T -> RUN at T+1 -> first fetch in cycle T+1 -> out_valid at T+2.
  - Steady state is one instruction per cycle when out_ready is high.
- FAULT:
  - No fetch; redirects are ignored.
  - Entries already queued remain deliverable.
  - Exited only by rst.

Optional Feature:
- IMEM_FETCH_PERF_EN defined: adds two output ports and two 32-bit counters, both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt: increments once per push.
  - perf_stall_cnt: increments on each RUN cycle with no push and no redirect.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package mips_fetch_pkg:
  - fetch_state_t enum (IDLE/RUN/FAULT).
  - INSTR_W = 32, PC_STEP = 4, FQ_DEPTH = 2.
  - fetch_entry_t struct {instr, pc}.
- Natural sub-module: fetch_queue, a 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count.
- The FSM and PC logic stay in imem_fetch_ctrl.

Test Plan:
- Reset, start at cycle 2, out_ready = 1, memory preloaded with 11 words:
  - out_pc = 0, 4, 8, ... on consecutive cycles from cycle 4.
  - out_instr matches word[pc/4].
- out_ready = 0 for 5 cycles after first valid:
  - Queue fills to 2, pc stops at 8, head stays 0.
  - Release gives pcs 0, 4, 8 in consecutive cycles with no gap or duplicate.
- redir_valid with redir_pc = 0x20 while the queue holds 2 entries:
  - out_valid = 0 next cycle.
  - Then out_pc = 0x20, 0x24, ...
- Run to pc = 0x7C (word 31), DEPTH = 32:
  - Word 31 is delivered.
  - Next cycle fault = 1, fault_pc = 0x80.
  - Subsequent redirect is ignored.
- Redirect to 0x06:
  - fault = 1, fault_pc = 0x06 one cycle after the redirect.
  - No push of 0x06.
- rst asserted mid-stream with 2 entries queued:
  - Next cycle out_valid = 0, fault = 0, state IDLE, imem_addr = RESET_PC >> 2.
  - A start then restarts fetch from RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the MIPS fetch stage.
//   fetch_state_t : fetch sequencer state (IDLE/RUN/FAULT)
//   fetch_entry_t : queued instruction word with its byte PC
package mips_fetch_pkg;
    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    localparam int FQ_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO of fetch_entry_t.
//   clk, rst : clock, synchronous active-high reset
//   push     : write entry at the tail
//   pop      : drop the head (caller only pops when count != 0)
//   flush    : empty the queue; wins over push/pop
//   entry    : data written on push
//   head     : oldest entry, held while not popped
//   count    : occupancy 0..2
module fetch_queue
    import mips_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t e0, e1;

    assign head = e0;

    // e0 is always the head; a pop shifts e1 forward, or takes the incoming
    // entry directly when only one word was queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop)
                e0 <= (count == 2'd2) ? e1 : entry;
            else if (push && count == 2'd0)
                e0 <= entry;
            if (push && (count == 2'd2 || (count == 2'd1 && !pop)))
                e1 <= entry;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC owner and fetch sequencer between instruction memory and decode.
//   clk, rst          : clock, synchronous active-high reset
//   start / stop      : pulses moving IDLE->RUN / RUN->IDLE
//   imem_addr         : word index (pc >> 2) to combinational-read memory
//   imem_rdata        : instruction word at imem_addr
//   out_valid/ready   : handshake to decode; out_instr/out_pc give the head entry
//   redir_valid/pc    : redirect from execute, flushes the queue
//   fault, fault_pc   : sticky fault on misaligned or out-of-range PC
//   IMEM_FETCH_PERF_EN: adds perf_fetch_cnt (pushes) and perf_stall_cnt
//                       (RUN cycles without push or redirect)
module imem_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    input  logic               redir_valid,
    input  logic [31:0]        redir_pc,
    output logic               fault,
    output logic [31:0]        fault_pc
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    localparam logic [29:0] LIMIT = 30'(DEPTH);

    fetch_state_t state;
    fetch_entry_t head;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic         run, pop, push, flush, bad, room;

    assign imem_addr = {2'b00, pc[31:2]};
    assign out_valid = count != 2'd0;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign run       = state == RUN;
    assign pop       = out_valid & out_ready;
    assign bad       = (pc[1:0] != 2'b00) || (pc[31:2] >= LIMIT);
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign room      = (count < 2'(FQ_DEPTH)) || pop;
    assign flush     = run & redir_valid;
    assign push      = run & !redir_valid & !bad & room;

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .entry ('{instr: imem_rdata, pc: pc}),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir_valid) pc <= redir_pc;
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (redir_valid) begin
                        pc    <= redir_pc;
                        state <= stop ? IDLE : RUN;
                    end else if (bad) begin
                        fault    <= 1'b1;
                        fault_pc <= pc;
                        state    <= FAULT;
                    end else begin
                        if (push) pc <= pc + 32'(PC_STEP);
                        if (stop) state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (run && !push && !redir_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule
